mem_bus_arbiter: RTL and testbench

Two-master arbiter sharing the single memory-mapped bus port (address/read/write/writedata/byteenable/readdata/waitrequest) of the RAM model between the CPU (`mips_cpu_bus`) and a second requester such as a program loader or DMA engine. It multiplexes the slave side to one granted master per transaction. Arbitration is round-robin. Non-granted masters are stalled through their own `waitrequest`. It sits between the masters and `ram_CPU` in the system top and in the CPU testbench.

---
 rtl/mem_bus_pkg.sv | 6 +
 rtl/mem_bus_arbiter_rr_pick2.sv | 8 +
 rtl/mem_bus_arbiter.sv | 77 +++++++
 tb/tb_mem_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: default bus widths and the arbiter state encoding shared by the memory bus blocks
package mem_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rr_pick2: two-requester round-robin picker; on a tie the requester not served last wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  assign pick = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory-mapped slave port between two masters
module mem_bus_arbiter #(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int DATA_W = mem_bus_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m0_read,
  input  logic                m1_read,
  input  logic                m0_write,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m0_waitrequest,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant,
  output logic [CNT_W-1:0]    m0_count,
  output logic [CNT_W-1:0]    m1_count
);
  import mem_bus_pkg::*;
  arb_state_t state;
  logic       last;
  logic [1:0] req, pick;
  logic       g0, g1, hold, done;
  assign req  = {m1_read | m1_write, m0_read | m0_write};
  assign g0   = state == GRANT0;
  assign g1   = state == GRANT1;
  assign hold = (g0 & req[0]) | (g1 & req[1]);
  assign done = hold & ~s_waitrequest;
  // the master completing this cycle counts as served for the re-pick
  rr_pick2 u_pick (.req(req), .last(done ? g1 : last), .pick(pick));
  always_comb begin
    s_address      = g0 ? m0_address : g1 ? m1_address : '0;
    s_read         = g0 ? m0_read : g1 ? m1_read : 1'b0;
    s_write        = g0 ? m0_write : g1 ? m1_write : 1'b0;
    s_writedata    = g0 ? m0_writedata : g1 ? m1_writedata : '0;
    s_byteenable   = g0 ? m0_byteenable : g1 ? m1_byteenable : '0;
    m0_waitrequest = g0 ? s_waitrequest : req[0];
    m1_waitrequest = g1 ? s_waitrequest : req[1];
    m0_readdata    = g0 ? s_readdata : '0;
    m1_readdata    = g1 ? s_readdata : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      grant    <= '0;
      m0_count <= '0;
      m1_count <= '0;
    end else begin
      if (state == IDLE || done) begin
        state <= pick[0] ? GRANT0 : pick[1] ? GRANT1 : IDLE;
        grant <= pick;
      end else if (!hold) begin
        state <= IDLE;
        grant <= '0;
      end
      if (done) last <= g1;
      if (done && g0 && !(&m0_count)) m0_count <= m0_count + 1'b1;
      if (done && g1 && !(&m1_count)) m1_count <= m1_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench driving two self-running masters against a zero-latency slave model
module tb_mem_bus_arbiter;
  localparam logic [31:0] K = 32'h5A5A_A5A5;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m1_read = 1'b0, m0_write = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest = 1'b0;
  logic [1:0]  grant;
  logic [15:0] m0_count, m1_count;
  int          vectors = 0, miscompares = 0;
  cmd_t        cmd_q0[$], cmd_q1[$], exp_q0[$], exp_q1[$];
  bit          sw_q[$];
  logic [1:0]  grant_log[$];
  logic        wait0_log[$];
  int          served_q[$];
  bit          act0, act1, done0, done1;

  assign s_readdata = s_address ^ K;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m1_address(m1_address),
    .m0_read(m0_read), .m1_read(m1_read),
    .m0_write(m0_write), .m1_write(m1_write),
    .m0_writedata(m0_writedata), .m1_writedata(m1_writedata),
    .m0_byteenable(m0_byteenable), .m1_byteenable(m1_byteenable),
    .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
    .m0_waitrequest(m0_waitrequest), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .m0_count(m0_count), .m1_count(m1_count)
  );

  initial forever #5 clk = ~clk;

  task automatic clear_logs();
    grant_log.delete();
    wait0_log.delete();
    served_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    {m0_read, m0_write, m1_read, m1_write, s_waitrequest} = '0;
    {act0, act1, done0, done1} = '0;
    cmd_q0.delete(); cmd_q1.delete(); exp_q0.delete(); exp_q1.delete(); sw_q.delete();
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic run_cycles(input int n);
    cmd_t c;
    repeat (n) begin
      @(negedge clk);
      s_waitrequest = sw_q.size() > 0 ? sw_q.pop_front() : 1'b0;
      if (!act0 || done0) begin
        if (cmd_q0.size() > 0) begin
          c = cmd_q0.pop_front();
          m0_address = c.addr; m0_read = !c.wr; m0_write = c.wr;
          m0_writedata = c.data; m0_byteenable = c.be;
          exp_q0.push_back(c); act0 = 1'b1;
        end else begin
          m0_read = 1'b0; m0_write = 1'b0; act0 = 1'b0;
        end
      end
      if (!act1 || done1) begin
        if (cmd_q1.size() > 0) begin
          c = cmd_q1.pop_front();
          m1_address = c.addr; m1_read = !c.wr; m1_write = c.wr;
          m1_writedata = c.data; m1_byteenable = c.be;
          exp_q1.push_back(c); act1 = 1'b1;
        end else begin
          m1_read = 1'b0; m1_write = 1'b0; act1 = 1'b0;
        end
      end
      #2;
      grant_log.push_back(grant);
      wait0_log.push_back(m0_waitrequest);
      done0 = act0 && !m0_waitrequest;
      done1 = act1 && !m1_waitrequest;
      if (done0) begin
        c = exp_q0.pop_front();
        vectors++;
        if (grant !== 2'b01 || s_address !== c.addr || s_write !== c.wr || s_read !== !c.wr ||
            s_byteenable !== c.be || (c.wr ? s_writedata !== c.data : m0_readdata !== (c.addr ^ K))) begin
          miscompares++;
          $display("FAIL m0_xfer got grant=%b addr=%h rd=%b wr=%b wdata=%h be=%h rdata=%h exp addr=%h wr=%b wdata=%h be=%h rdata=%h",
                   grant, s_address, s_read, s_write, s_writedata, s_byteenable, m0_readdata,
                   c.addr, c.wr, c.data, c.be, c.addr ^ K);
        end
        served_q.push_back(0);
      end
      if (done1) begin
        c = exp_q1.pop_front();
        vectors++;
        if (grant !== 2'b10 || s_address !== c.addr || s_write !== c.wr || s_read !== !c.wr ||
            s_byteenable !== c.be || (c.wr ? s_writedata !== c.data : m1_readdata !== (c.addr ^ K))) begin
          miscompares++;
          $display("FAIL m1_xfer got grant=%b addr=%h rd=%b wr=%b wdata=%h be=%h rdata=%h exp addr=%h wr=%b wdata=%h be=%h rdata=%h",
                   grant, s_address, s_read, s_write, s_writedata, s_byteenable, m1_readdata,
                   c.addr, c.wr, c.data, c.be, c.addr ^ K);
        end
        served_q.push_back(1);
      end
      vectors++;
      if ((!act0 && m0_waitrequest !== 1'b0) || (!act1 && m1_waitrequest !== 1'b0)) begin
        miscompares++;
        $display("FAIL idle_wait got w0=%b w1=%b exp 0 for non-requesting master", m0_waitrequest, m1_waitrequest);
      end
    end
  endtask

  task automatic check_counts(input string name, input logic [15:0] e0, input logic [15:0] e1);
    vectors++;
    if (m0_count !== e0 || m1_count !== e1) begin
      miscompares++;
      $display("FAIL %s_counts got %h/%h exp %h/%h", name, m0_count, m1_count, e0, e1);
    end
  endtask

  task automatic test_reset();
    m0_read = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (grant !== 2'b00 || m0_count !== 16'h0 || m1_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_regs got grant=%b counts=%h/%h exp 00 0/0", grant, m0_count, m1_count);
    end
    vectors++;
    if (s_read !== 1'b0 || s_write !== 1'b0 || s_address !== '0 || s_writedata !== '0 || s_byteenable !== '0) begin
      miscompares++;
      $display("FAIL reset_slave got rd=%b wr=%b addr=%h wd=%h be=%h exp all 0", s_read, s_write, s_address, s_writedata, s_byteenable);
    end
    vectors++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0 || m0_readdata !== '0 || m1_readdata !== '0) begin
      miscompares++;
      $display("FAIL reset_master got w0=%b w1=%b rd0=%h rd1=%h exp 1 0 0 0", m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata);
    end
    m0_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    logic [1:0] eg [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    do_reset();
    cmd_q0.push_back('{1'b0, 32'hBFC0_0000, 32'h0, 4'hF});
    run_cycles(4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (grant_log[i] !== eg[i]) begin
        miscompares++;
        $display("FAIL single_grant[%0d] got %b exp %b", i, grant_log[i], eg[i]);
      end
    end
    vectors++;
    if (served_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_served got %0d completions exp 1", served_q.size());
    end
    check_counts("single", 16'd1, 16'd0);
  endtask

  task automatic test_tie_from_idle();
    logic [1:0] eg [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    do_reset();
    cmd_q0.push_back('{1'b0, 32'h0000_0100, 32'h0, 4'hF});
    cmd_q1.push_back('{1'b0, 32'h0000_0200, 32'h0, 4'h3});
    run_cycles(5);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (grant_log[i] !== eg[i]) begin
        miscompares++;
        $display("FAIL tie_grant[%0d] got %b exp %b", i, grant_log[i], eg[i]);
      end
    end
    vectors++;
    if (served_q.size() != 2 || served_q[0] != 0 || served_q[1] != 1) begin
      miscompares++;
      $display("FAIL tie_order got n=%0d first=%0d exp n=2 order 0,1", served_q.size(), served_q.size() > 0 ? served_q[0] : -1);
    end
    check_counts("tie", 16'd1, 16'd1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd_q0.push_back('{1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 4'hF});
      cmd_q1.push_back('{1'b1, 32'h0000_2000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'(1 << i)});
    end
    run_cycles(11);
    vectors++;
    if (served_q.size() != 8) begin
      miscompares++;
      $display("FAIL b2b_served got %0d completions exp 8", served_q.size());
    end
    for (int i = 0; i < served_q.size(); i++) begin
      vectors++;
      if (served_q[i] != (i % 2)) begin
        miscompares++;
        $display("FAIL b2b_order[%0d] got m%0d exp m%0d", i, served_q[i], i % 2);
      end
    end
    check_counts("b2b", 16'd4, 16'd4);
  endtask

  task automatic test_stall();
    logic [1:0] eg [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    logic       ew [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    cmd_q1.push_back('{1'b0, 32'h0000_3000, 32'h0, 4'hF});
    run_cycles(1);
    clear_logs();
    cmd_q0.push_back('{1'b1, 32'h0000_4000, 32'h1234_5678, 4'hC});
    sw_q = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_cycles(7);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (grant_log[i] !== eg[i] || wait0_log[i] !== ew[i]) begin
        miscompares++;
        $display("FAIL stall_cycle[%0d] got grant=%b w0=%b exp grant=%b w0=%b", i, grant_log[i], wait0_log[i], eg[i], ew[i]);
      end
    end
    vectors++;
    if (served_q.size() != 2 || served_q[0] != 1 || served_q[1] != 0) begin
      miscompares++;
      $display("FAIL stall_order got n=%0d exp order 1,0", served_q.size());
    end
    check_counts("stall", 16'd1, 16'd1);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    cmd_q0.push_back('{1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF});
    sw_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_cycles(2);
    vectors++;
    if (s_write !== 1'b1 || grant !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_pre got wr=%b grant=%b exp 1 01", s_write, grant);
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (s_write !== 1'b0 || s_address !== '0 || s_writedata !== '0 || grant !== 2'b00 || m0_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_drop got wr=%b addr=%h wd=%h grant=%b w0=%b exp 0 0 0 00 1", s_write, s_address, s_writedata, grant, m0_waitrequest);
    end
    check_counts("midrst", 16'd0, 16'd0);
    m0_write = 1'b0;
    {act0, done0, s_waitrequest} = '0;
    exp_q0.delete();
    sw_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (grant !== 2'b00 || s_write !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle got grant=%b wr=%b exp 00 0", grant, s_write);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] e;
    do_reset();
    @(negedge clk);
    m0_address = 32'h0000_5000; m0_read = 1'b1; m0_byteenable = 4'hF;
    for (int k = 2; k <= 65540; k++) begin
      @(negedge clk); #1;
      if (k == 65536 || k == 65537 || k == 65540) begin
        e = (k - 2 > 65535) ? 16'hFFFF : 16'(k - 2);
        vectors++;
        if (m0_count !== e) begin
          miscompares++;
          $display("FAIL sat_count[k=%0d] got %h exp %h", k, m0_count, e);
        end
      end
    end
    m0_read = 1'b0;
    check_counts("sat", 16'hFFFF, 16'd0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_from_idle();
    test_back_to_back();
    test_stall();
    test_reset_mid_write();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
